// File: rtl/datapath_pkg.sv
// Shared opcode encodings, sequencer states and bus-source selects for the
// single-bus register datapath.
package datapath_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SHR  = 4'h4;
  localparam logic [3:0] OP_SHRA = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_ROL  = 4'h8;
  localparam logic [3:0] OP_NEG  = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_ADDI = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TY,
    S_TZ,
    S_TWB,
    S_THI
  } state_t;

  // One-hot bus driver selects; at most one source drives the bus per state.
  localparam int         BUS_SRCS = 5;
  localparam logic [4:0] BUS_RB   = 5'b00001;
  localparam logic [4:0] BUS_RC   = 5'b00010;
  localparam logic [4:0] BUS_IMM  = 5'b00100;
  localparam logic [4:0] BUS_ZLO  = 5'b01000;
  localparam logic [4:0] BUS_ZHI  = 5'b10000;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: a comes from Y, b from the bus; produces a 2*DATA_W
// result split into z_hi/z_lo and flags unknown opcodes.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] z_hi,
  output logic [DATA_W-1:0] z_lo,
  output logic              illegal
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]            sh;
  logic signed [DATA_W-1:0]   a_s;
  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod;

  assign sh    = b[SH_W-1:0];
  assign a_s   = a;
  assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod  = a_ext * b_ext;

  function automatic logic [DATA_W-1:0] sign_fill(input logic [DATA_W-1:0] v);
    return {DATA_W{v[DATA_W-1]}};
  endfunction

  always_comb begin
    z_lo    = '0;
    z_hi    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  begin z_lo = a + b; z_hi = sign_fill(a + b); end
      OP_SUB:  begin z_lo = a - b; z_hi = sign_fill(a - b); end
      OP_AND:  z_lo = a & b;
      OP_OR:   z_lo = a | b;
      OP_SHR:  z_lo = a >> sh;
      OP_SHRA: z_lo = a_s >>> sh;
      OP_SHL:  z_lo = a << sh;
      // A shift by DATA_W yields zero, so sh == 0 degenerates cleanly.
      OP_ROR:  z_lo = (a >> sh) | (a << (DATA_W - int'(sh)));
      OP_ROL:  z_lo = (a << sh) | (a >> (DATA_W - int'(sh)));
      OP_NEG:  begin z_lo = -a; z_hi = sign_fill(-a); end
      OP_NOT:  z_lo = ~a;
      OP_ADDI: z_lo = a + b;
      OP_MUL:  {z_hi, z_lo} = prod;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_seq.sv
// Single-bus register datapath with an internal T-step sequencer that runs
// one register-to-register ALU instruction per op_valid/op_ready handshake.
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [SEL_W-1:0]  ra,
  input  logic [SEL_W-1:0]  rb,
  input  logic [SEL_W-1:0]  rc,
  input  logic [DATA_W-1:0] imm,
  input  logic              ext_wr_en,
  input  logic [SEL_W-1:0]  ext_wr_sel,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result
);

  state_t state, state_nxt;

  logic [3:0]          op_q;
  logic [SEL_W-1:0]    ra_q, rb_q, rc_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   y_q, z_hi_q, z_lo_q, hi_r, lo_r;
  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   alu_hi, alu_lo;
  logic                alu_illegal;
  logic [BUS_SRCS-1:0] bus_sel;
  logic                y_ld, z_ld, r_ld, lo_ld, hi_ld, fin;
  logic                accept, ext_ld;

  assign op_ready = (state == S_IDLE);
  assign accept   = op_ready && op_valid;
  assign ext_ld   = op_ready && ext_wr_en;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (op_valid) state_nxt = S_TY;
      S_TY:    state_nxt = S_TZ;
      S_TZ:    state_nxt = S_TWB;
      S_TWB:   state_nxt = (op_q == OP_MUL) ? S_THI : S_IDLE;
      S_THI:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus_sel = '0;
    y_ld    = 1'b0;
    z_ld    = 1'b0;
    r_ld    = 1'b0;
    lo_ld   = 1'b0;
    hi_ld   = 1'b0;
    fin     = 1'b0;
    case (state)
      S_TY: begin
        bus_sel = BUS_RB;
        y_ld    = 1'b1;
      end
      S_TZ: begin
        bus_sel = (op_q == OP_ADDI) ? BUS_IMM : BUS_RC;
        z_ld    = 1'b1;
      end
      S_TWB: begin
        bus_sel = BUS_ZLO;
        if (alu_illegal)            fin   = 1'b1;
        else if (op_q == OP_MUL)    lo_ld = 1'b1;
        else begin
          r_ld = 1'b1;
          fin  = 1'b1;
        end
      end
      S_THI: begin
        bus_sel = BUS_ZHI;
        hi_ld   = 1'b1;
        fin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus = ({DATA_W{bus_sel[0]}} & regs[rb_q])
             | ({DATA_W{bus_sel[1]}} & regs[rc_q])
             | ({DATA_W{bus_sel[2]}} & imm_q)
             | ({DATA_W{bus_sel[3]}} & z_lo_q)
             | ({DATA_W{bus_sel[4]}} & z_hi_q);

  datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .a       (y_q),
    .b       (bus),
    .op      (op_q),
    .z_hi    (alu_hi),
    .z_lo    (alu_lo),
    .illegal (alu_illegal)
  );

  // Request fields are captured at accept so the requester may move on.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= op_code;
      ra_q  <= ra;
      rb_q  <= rb;
      rc_q  <= rc;
      imm_q <= imm;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      y_q    <= '0;
      z_hi_q <= '0;
      z_lo_q <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      if (y_ld)  y_q <= bus;
      if (z_ld)  {z_hi_q, z_lo_q} <= {alu_hi, alu_lo};
      if (lo_ld) lo_r <= bus;
      if (hi_ld) hi_r <= bus;
    end
  end

  // External load happens only in IDLE and writeback only in T_WB.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (ext_ld) regs[ext_wr_sel] <= ext_wr_data;
      if (r_ld)   regs[ra_q]       <= bus;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= fin;
      err  <= fin && alu_illegal;
      if (fin) result <= alu_illegal ? '0 : z_lo_q;
    end
  end

  assign rd_data = regs[rd_sel];
  assign hi_q    = hi_r;
  assign lo_q    = lo_r;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq with an instruction-level reference model
// checked against the DUT on every cycle.
module tb_datapath_seq;

  localparam int W  = 32;
  localparam int NR = 16;
  localparam int SW = 4;

  logic          clk, clr, op_valid, op_ready;
  logic [3:0]    op_code;
  logic [SW-1:0] ra, rb, rc, ext_wr_sel, rd_sel;
  logic [W-1:0]  imm, ext_wr_data, rd_data, hi_q, lo_q, result;
  logic          ext_wr_en, done, err;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model state
  logic [W-1:0]  m_r [NR];
  logic [W-1:0]  m_hi, m_lo, e_res, e_hi;
  logic          pend, e_err, e_mul;
  logic [SW-1:0] e_ra;
  int            cnt;

  datapath_seq #(.DATA_W(W), .NUM_REGS(NR)) dut (
    .clk(clk), .clr(clr), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
    .ext_wr_en(ext_wr_en), .ext_wr_sel(ext_wr_sel), .ext_wr_data(ext_wr_data),
    .rd_sel(rd_sel), .rd_data(rd_data), .hi_q(hi_q), .lo_q(lo_q),
    .done(done), .err(err), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Instruction semantics at the arithmetic level: returns {hi, lo}.
  function automatic logic [2*W-1:0] model_alu(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, output logic bad);
    logic [W-1:0] lo;
    int unsigned  s;
    longint       p;
    lo  = '0;
    bad = 1'b0;
    s   = int'(b[4:0]);
    case (op)
      4'h0: lo = a + b;
      4'h1: lo = a - b;
      4'h2: lo = a & b;
      4'h3: lo = a | b;
      4'h4: lo = a >> s;
      4'h5: lo = $signed(a) >>> s;
      4'h6: lo = a << s;
      4'h7: begin lo = a; for (int k = 0; k < int'(s); k++) lo = {lo[0], lo[W-1:1]}; end
      4'h8: begin lo = a; for (int k = 0; k < int'(s); k++) lo = {lo[W-2:0], lo[W-1]}; end
      4'h9: lo = 32'd0 - a;
      4'hA: lo = ~a;
      4'hB: lo = a + b;
      4'hC: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      default: bad = 1'b1;
    endcase
    return {32'd0, lo};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_r[i] = '0;
    m_hi = '0;
    m_lo = '0;
    pend = 1'b0;
    cnt  = 0;
  endtask

  task automatic compare_loop();
    logic [2*W-1:0] r;
    logic           bad, exp_done;
    forever begin
      @(posedge clk);
      if (!clr) model_reset();
      else begin
        if (pend) cnt--;
        if (!pend) begin
          if (ext_wr_en) m_r[ext_wr_sel] = ext_wr_data;
          if (op_valid) begin
            r     = model_alu(op_code, m_r[rb], (op_code == 4'hB) ? imm : m_r[rc], bad);
            e_err = bad;
            e_res = bad ? '0 : r[W-1:0];
            e_hi  = r[2*W-1:W];
            e_mul = (op_code == 4'hC);
            e_ra  = ra;
            pend  = 1'b1;
            cnt   = e_mul ? 4 : 3;
          end
        end
      end
      @(negedge clk);
      if (!clr) model_reset();
      exp_done = pend && (cnt == 0);
      chk("done", done, exp_done);
      chk("op_ready", op_ready, !pend || cnt == 0);
      if (exp_done) begin
        chk("result", result, e_res);
        chk("err", err, e_err);
        if (!e_err) begin
          if (e_mul) begin m_lo = e_res; m_hi = e_hi; end
          else m_r[e_ra] = e_res;
        end
        pend = 1'b0;
      end
      if (!pend) begin
        chk("rd_data", rd_data, m_r[rd_sel]);
        chk("hi_q", hi_q, m_hi);
        chk("lo_q", lo_q, m_lo);
      end
    end
  endtask

  // Stimulus tasks start and end just after a rising edge.
  task automatic ext_load(input logic [SW-1:0] sel, input logic [W-1:0] d);
    ext_wr_en = 1'b1; ext_wr_sel = sel; ext_wr_data = d;
    @(posedge clk); #1;
    ext_wr_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [SW-1:0] a, b, c, input logic [W-1:0] im);
    op_valid = 1'b1; op_code = op; ra = a; rb = b; rc = c; imm = im;
    @(posedge clk); #1;
    op_valid = 1'b0; ext_wr_en = 1'b0;
    op_code = 4'hF; ra = '1; rb = '1; rc = '1; imm = '1;
  endtask

  task automatic wait_done(output logic [W-1:0] res, output logic e, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    repeat (8) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin got = 1'b1; break; end
    end
    chk("done_seen", got, 1'b1);
    res = result;
    e   = err;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [SW-1:0] a, b, c, input logic [W-1:0] im,
                        output logic [W-1:0] res, output logic e, output int lat);
    issue(op, a, b, c, im);
    wait_done(res, e, lat);
  endtask

  task automatic sweep();
    for (int i = 0; i < NR; i++) begin
      rd_sel = SW'(i);
      @(posedge clk); #1;
    end
  endtask

  task automatic peek(input string name, input logic [SW-1:0] sel, input logic [W-1:0] exp);
    rd_sel = sel;
    #1;
    chk(name, rd_data, exp);
  endtask

  initial begin
    logic [W-1:0] res;
    logic         e;
    int           lat;
    clr = 1'b0; op_valid = 1'b0; op_code = '0; ra = '0; rb = '0; rc = '0; imm = '0;
    ext_wr_en = 1'b0; ext_wr_sel = '0; ext_wr_data = '0; rd_sel = '0;
    model_reset();
    fork
      compare_loop();
      begin
        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_hi", hi_q, 32'h0);
        chk("rst_lo", lo_q, 32'h0);
        clr = 1'b1;
        sweep();

        // 2: ADD
        ext_load(4'd1, 32'd5);
        ext_load(4'd2, 32'd3);
        run_op(4'h0, 4'd3, 4'd1, 4'd2, 32'd0, res, e, lat);
        chk("add_lat", lat, 3);
        chk("add_res", res, 32'd8);
        peek("add_r3", 4'd3, 32'd8);

        // 3: SUB, ROR, other ops on 0x8000_0001 / 33
        ext_load(4'd1, 32'h0000_0001);
        run_op(4'h1, 4'd4, 4'd1, 4'd2, 32'd0, res, e, lat);
        chk("sub_res", res, 32'hFFFF_FFFE);
        ext_load(4'd9, 32'h8000_0001);
        ext_load(4'd10, 32'd33);
        run_op(4'h7, 4'd5, 4'd9, 4'd10, 32'd0, res, e, lat);
        chk("ror_res", res, 32'hC000_0000);
        peek("ror_r5", 4'd5, 32'hC000_0000);
        run_op(4'h5, 4'd15, 4'd9, 4'd10, 32'd0, res, e, lat);
        chk("shra_res", res, 32'hC000_0000);
        run_op(4'h8, 4'd15, 4'd9, 4'd10, 32'd0, res, e, lat);
        chk("rol_res", res, 32'h0000_0003);
        run_op(4'h4, 4'd15, 4'd9, 4'd10, 32'd0, res, e, lat);
        chk("shr_res", res, 32'h4000_0000);
        run_op(4'h6, 4'd15, 4'd9, 4'd10, 32'd0, res, e, lat);
        run_op(4'h2, 4'd15, 4'd9, 4'd10, 32'd0, res, e, lat);
        run_op(4'h3, 4'd15, 4'd9, 4'd10, 32'd0, res, e, lat);
        run_op(4'h9, 4'd15, 4'd2, 4'd0, 32'd0, res, e, lat);
        chk("neg_res", res, 32'hFFFF_FFFD);
        run_op(4'hA, 4'd15, 4'd9, 4'd0, 32'd0, res, e, lat);
        run_op(4'hB, 4'd11, 4'd1, 4'd1, 32'hFFFF_FFFF, res, e, lat);
        chk("addi_wrap", res, 32'h0);
        run_op(4'h0, 4'd1, 4'd1, 4'd1, 32'd0, res, e, lat);
        chk("add_alias", res, 32'd2);
        // ext write and accept in the same cycle
        ext_wr_en = 1'b1; ext_wr_sel = 4'd2; ext_wr_data = 32'd10;
        run_op(4'h0, 4'd11, 4'd2, 4'd2, 32'd0, res, e, lat);
        chk("ext_same_cycle", res, 32'd20);
        sweep();

        // 4: MUL
        ext_load(4'd6, 32'hFFFF_FFF9);
        ext_load(4'd7, 32'd3);
        run_op(4'hC, 4'd0, 4'd6, 4'd7, 32'd0, res, e, lat);
        chk("mul_lat", lat, 4);
        chk("mul_res", res, 32'hFFFF_FFEB);
        chk("mul_lo", lo_q, 32'hFFFF_FFEB);
        chk("mul_hi", hi_q, 32'hFFFF_FFFF);
        peek("mul_r0", 4'd0, 32'h0);

        // 5: illegal opcode; op_valid and ext write in T_Z ignored
        issue(4'hE, 4'd13, 4'd1, 4'd2, 32'd0);
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = 4'h0; ra = 4'd14; rb = 4'd1; rc = 4'd1;
        ext_wr_en = 1'b1; ext_wr_sel = 4'd12; ext_wr_data = 32'h55;
        @(posedge clk); #1;
        op_valid = 1'b0; ext_wr_en = 1'b0;
        @(posedge clk); #1;
        chk("ill_done", done, 1'b1);
        chk("ill_err", err, 1'b1);
        chk("ill_result", result, 32'h0);
        @(posedge clk); #1;
        chk("ill_done_pulse", done, 1'b0);
        peek("ill_r12", 4'd12, 32'h0);
        peek("ill_r13", 4'd13, 32'h0);
        peek("ill_r14", 4'd14, 32'h0);
        sweep();

        // 6: reset during T_Z
        ext_load(4'd1, 32'd4);
        ext_load(4'd2, 32'd6);
        issue(4'h0, 4'd8, 4'd1, 4'd2, 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        #1;
        chk("abort_ready", op_ready, 1'b1);
        chk("abort_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        peek("abort_r8", 4'd8, 32'h0);
        chk("abort_ready_rel", op_ready, 1'b1);
        sweep();
        ext_load(4'd1, 32'd2);
        run_op(4'h0, 4'd8, 4'd1, 4'd1, 32'd0, res, e, lat);
        chk("recover_res", res, 32'd4);
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
      end
      begin
        #200000;
        $display("FAIL watchdog: bench did not finish, passed %0d of %0d", n_pass, n_tot);
        $fatal(1, "watchdog");
      end
    join
  end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised single-bus datapath: N general registers, Y, 2×W Z, HI, LO, plus an internal T-step sequencer.
- Runs one register-to-register ALU instruction per handshake: Rb→Y, Rc/imm→ALU→Z, Z→Ra (and HI/LO).
- Replaces hand-driven Rx_In/Rx_Out control strobes with an opcode interface; sits below the future control unit.

Parameters:
- DATA_W, 32, register/bus width (≥8, power of two)
- NUM_REGS, 16, general-purpose register count (≥2)
- SEL_W, $clog2(NUM_REGS), register-select width (derived)

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- op_valid  in  1  instruction request
- op_ready  out  1  high in IDLE only
- op_code  in  4  operation (see Behaviour)
- ra / rb / rc  in  SEL_W each  destination / source A / source B
- imm  in  DATA_W  immediate for ADDI
- ext_wr_en  in  1  external register load
- ext_wr_sel  in  SEL_W  register to load
- ext_wr_data  in  DATA_W  load data
- rd_sel  in  SEL_W  debug read select
- rd_data  out  DATA_W  combinational read of R[rd_sel]
- hi_q / lo_q  out  DATA_W  HI and LO contents
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: illegal opcode
- result  out  DATA_W  Z low word, valid with done

Behaviour:
- Reset (clr=0, async):
  - All registers, Y, Z, HI, LO = 0.
  - FSM = IDLE; op_ready = 1; done = 0; err = 0; result = 0.
- Opcodes:
  - 0 ADD; 1 SUB (Rb−Rc); 2 AND; 3 OR; 4 SHR (logical); 5 SHRA; 6 SHL; 7 ROR; 8 ROL; 9 NEG (−Rb); A NOT (~Rb); B ADDI (Rb+imm); C MUL (signed, 2·DATA_W product).
  - D–F illegal.
- Arithmetic and width:
  - Shift/rotate amount = Rc[$clog2(DATA_W)-1:0].
  - ADD/SUB/ADDI wrap modulo 2^DATA_W; no carry/overflow output.
- FSM: IDLE → T_Y → T_Z → T_WB → [T_HI] → IDLE.
  - IDLE: when op_valid && op_ready, latch op_code/ra/rb/rc/imm. The request inputs may change afterwards.
  - T_Y: bus = R[rb]; Y ← bus.
  - T_Z: bus = R[rc] (imm for ADDI); Z ← ALU(Y, bus).
    - Non-MUL ops: Z high word = sign extension for NEG/ADD/SUB, 0 otherwise.
  - T_WB, non-MUL: bus = Z_lo; R[ra] ← bus; done = 1 with result = Z_lo; return to IDLE.
  - T_WB, MUL: LO ← Z_lo; go to T_HI.
  - T_HI: HI ← Z_hi; done = 1 with result = Z_lo.
  - Illegal opcode: no R/HI/LO write in T_WB; done = 1, err = 1, result = 0.
- Latency: accept edge + 3 cycles to done (4 for MUL). Next op can be accepted in the cycle after done.
- ra == rb or ra == rc: sources are read before writeback, so old values are used.
- ext_wr_en:
  - Honoured only in IDLE; ignored in all other states.
  - ext write and op accept in the same IDLE cycle: both occur. The op sees the new value because T_Y reads after the edge.
- Bus: single internal DATA_W bus with a one-hot source mux per state.
- Reset mid-operation: abort immediately to reset values. No partial writeback completes and no done is issued.
- No op_valid while busy: the request is held off by op_ready = 0 and is not queued.

Decomposition:
- Shared package datapath_pkg:
  - op_code localparams (OP_ADD … OP_MUL).
  - FSM state enum (S_IDLE, S_TY, S_TZ, S_TWB, S_THI).
- One sub-module: datapath_alu (combinational, parametrised DATA_W; inputs a, b, op; outputs z_hi, z_lo, illegal).

Test Plan:
1. Reset then rd_sel sweep → every R, hi_q, lo_q = 0; op_ready = 1.
2. ext load R1=5, R2=3; ADD ra=3 rb=1 rc=2 → done 3 cycles after accept, result = 8, R3 = 8.
3. R1=0x0000_0001; SUB R4 = R1 − R2 with R2=3 → 0xFFFF_FFFE.
   - Then ROR R5 = 0x8000_0001 by R[rc]=33 (amount 1) → 0xC000_0000.
4. R6 = −7 (0xFFFF_FFF9), R7=3; MUL → done 4 cycles after accept; lo_q = 0xFFFF_FFEB, hi_q = 0xFFFF_FFFF; no R written.
5. op_code = 0xE → done with err = 1, result = 0, no register change.
   - op_valid and ext_wr_en asserted during T_Z → both ignored.
6. Pull clr low during T_Z of ADD R8 ← … → no done pulse, R8 = 0, FSM in IDLE, op_ready = 1 after release.
